fcn_mlp_engine: RTL and testbench

Parametrised two-layer fully connected engine. FC1 is computed by `NUM_PE` parallel MAC lanes fed from a handshaked weight stream. The block adds a per-neuron bias, ReLU, and a rounding requantiser back to 8 bits. FC2 is computed for `OUT_N` logits in parallel, followed by an argmax. It sits after the feature/conv stage and is the classifier head of the NPU.

---
 rtl/fcn_pkg.sv | 22 ++
 rtl/pe_mac.sv | 24 ++
 rtl/fcn_mlp_engine.sv | 159 +++++++++++++++
 tb/tb_fcn_mlp_engine.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fcn_pkg.sv
// fcn_pkg: shared defaults, FSM states and saturation helpers for the MLP engine
package fcn_pkg;

    localparam int IN1_N_DEF  = 132;
    localparam int HID_N_DEF  = 10;
    localparam int OUT_N_DEF  = 2;
    localparam int NUM_PE_DEF = 4;
    localparam int ACC_W_DEF  = 24;

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, REDUCE, FC2, FIN} state_t;

    function automatic logic [7:0] sat_u8(input logic [63:0] v);
        return (v > 64'd255) ? 8'd255 : v[7:0];
    endfunction

    function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
        logic signed [63:0] mx;
        mx = (64'sd1 <<< (w - 1)) - 64'sd1;
        return (v > mx) ? mx : (v < -mx - 64'sd1) ? -mx - 64'sd1 : v;
    endfunction

endpackage

// File: rtl/pe_mac.sv
// pe_mac: one FC1 lane, signed weight times unsigned feature into a wrapping accumulator
module pe_mac import fcn_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [7:0]       w,
    input  logic [7:0]       x,
    output logic [ACC_W-1:0] acc
);

    logic [ACC_W-1:0] acc_q, acc_d;

    // clear wins over accumulate; feature is zero-extended so it stays unsigned
    always_comb acc_d = clr ? '0 : en ? acc_q + ACC_W'($signed(w) * $signed({1'b0, x})) : acc_q;

    // lane accumulator register
    always_ff @(posedge clk) acc_q <= rst_n ? acc_d : '0;

    assign acc = acc_q;

endmodule

// File: rtl/fcn_mlp_engine.sv
// fcn_mlp_engine: two-layer FC classifier head with streamed FC1 weights and argmax
module fcn_mlp_engine import fcn_pkg::*; #(
    parameter int IN1_N  = IN1_N_DEF,
    parameter int HID_N  = HID_N_DEF,
    parameter int OUT_N  = OUT_N_DEF,
    parameter int NUM_PE = NUM_PE_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    localparam int CW    = OUT_N > 1 ? $clog2(OUT_N) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [IN1_N-1:0][7:0]              in_vec,
    input  logic [NUM_PE-1:0][7:0]             w_data,
    input  logic                               w_valid,
    output logic                               w_ready,
    input  logic [HID_N-1:0][ACC_W-1:0]        fc1_bias,
    input  logic [4:0]                         cfg_shift,
    input  logic [OUT_N-1:0][HID_N-1:0][7:0]   fc2_w,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    output logic [OUT_N-1:0][ACC_W-1:0]        logits,
    output logic [CW-1:0]                      class_idx
);

    localparam int B  = (IN1_N + NUM_PE - 1) / NUM_PE;
    localparam int BW = B > 1 ? $clog2(B) : 1;
    localparam int NW = HID_N > 1 ? $clog2(HID_N) : 1;
    localparam int XW = IN1_N > 1 ? $clog2(IN1_N) : 1;
    localparam int SW = ACC_W + $clog2(NUM_PE) + 1;
    localparam int FW = ACC_W + 16;

    state_t                      state_q, state_d;
    logic [BW-1:0]               beat_q, beat_d;
    logic [NW-1:0]               n_q, n_d, k_q, k_d;
    logic [4:0]                  shift_q, shift_d;
    logic [7:0]                  hid_q [HID_N];
    logic [7:0]                  hid_d [HID_N];
    logic signed [FW-1:0]        acc2_q [OUT_N];
    logic signed [FW-1:0]        acc2_d [OUT_N];
    logic signed [FW-1:0]        sum2 [OUT_N];
    logic [OUT_N-1:0][ACC_W-1:0] logits_q, logits_d, lg;
    logic [CW-1:0]               cls_q, cls_d, best;
    logic [ACC_W-1:0]            lane_acc [NUM_PE];
    logic [7:0]                  lane_x [NUM_PE];
    logic signed [SW-1:0]        s;
    logic [63:0]                 t;

    assign w_ready   = state_q == STREAM;
    assign busy      = state_q != IDLE && state_q != FIN;
    assign done      = state_q == FIN;
    assign logits    = logits_q;
    assign class_idx = cls_q;

    // feature window for the current beat; lanes past the input length see zero
    always_comb
        for (int p = 0; p < NUM_PE; p++)
            lane_x[p] = (int'(beat_q) * NUM_PE + p < IN1_N) ? in_vec[XW'(int'(beat_q) * NUM_PE + p)] : 8'd0;

    for (genvar p = 0; p < NUM_PE; p++) begin : g_lane
        pe_mac #(.ACC_W(ACC_W)) u_mac (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (state_q == CLEAR),
            .en    (w_ready && w_valid),
            .w     (w_data[p]),
            .x     (lane_x[p]),
            .acc   (lane_acc[p])
        );
    end

    // lane reduction plus bias, then ReLU and round-half-up right shift
    always_comb begin
        s = SW'($signed(fc1_bias[n_q]));
        for (int p = 0; p < NUM_PE; p++) s = s + SW'($signed(lane_acc[p]));
        t = s[SW-1] ? '0 : (64'(s) + ((64'd1 << shift_q) >> 1)) >> shift_q;
    end

    // FC2 step for all logits at once, saturated candidates and lowest-index argmax
    always_comb begin
        best = '0;
        for (int o = 0; o < OUT_N; o++) begin
            sum2[o] = acc2_q[o] + FW'($signed(fc2_w[o][k_q]) * $signed({1'b0, hid_q[k_q]}));
            lg[o]   = ACC_W'(sat_s(64'(sum2[o]), ACC_W));
        end
        for (int o = 1; o < OUT_N; o++) if ($signed(lg[o]) > $signed(lg[best])) best = CW'(o);
    end

    // sequencing: per-neuron clear/stream/reduce, then FC2 and a single finish cycle
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        n_d      = n_q;
        k_d      = k_q;
        shift_d  = shift_q;
        hid_d    = hid_q;
        acc2_d   = acc2_q;
        logits_d = logits_q;
        cls_d    = cls_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = CLEAR;
                shift_d = cfg_shift;
                beat_d  = '0;
                n_d     = '0;
                k_d     = '0;
            end
            CLEAR: state_d = STREAM;
            STREAM: if (w_valid) begin
                beat_d  = beat_q == BW'(B - 1) ? '0 : beat_q + 1'b1;
                state_d = beat_q == BW'(B - 1) ? REDUCE : STREAM;
            end
            REDUCE: begin
                hid_d[n_q] = sat_u8(t);
                k_d        = '0;
                n_d        = n_q == NW'(HID_N - 1) ? n_q : n_q + 1'b1;
                state_d    = n_q == NW'(HID_N - 1) ? FC2 : CLEAR;
                if (n_q == NW'(HID_N - 1)) acc2_d = '{default: '0};
            end
            FC2: begin
                acc2_d = sum2;
                k_d    = k_q + 1'b1;
                if (k_q == NW'(HID_N - 1)) begin
                    state_d  = FIN;
                    logits_d = lg;
                    cls_d    = best;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            n_q      <= '0;
            k_q      <= '0;
            shift_q  <= '0;
            hid_q    <= '{default: '0};
            acc2_q   <= '{default: '0};
            logits_q <= '0;
            cls_q    <= '0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            n_q      <= n_d;
            k_q      <= k_d;
            shift_q  <= shift_d;
            hid_q    <= hid_d;
            acc2_q   <= acc2_d;
            logits_q <= logits_d;
            cls_q    <= cls_d;
        end
    end

endmodule

// File: tb/tb_fcn_mlp_engine.sv
// tb_fcn_mlp_engine: scoreboard bench for the MLP engine against an arithmetic reference
module tb_fcn_mlp_engine;
    import fcn_pkg::*;

    localparam int IN1_N  = 132;
    localparam int HID_N  = 10;
    localparam int OUT_N  = 2;
    localparam int NUM_PE = 4;
    localparam int ACC_W  = 24;
    localparam int B      = (IN1_N + NUM_PE - 1) / NUM_PE;
    localparam int PAD_N  = 130;

    logic clk = 0;
    logic rst_n = 0;
    logic [IN1_N-1:0][7:0]            in_vec;
    logic [NUM_PE-1:0][7:0]           w_data, pw_data;
    logic                             w_valid, w_ready, pw_ready;
    logic [HID_N-1:0][ACC_W-1:0]      fc1_bias;
    logic [4:0]                       cfg_shift;
    logic [OUT_N-1:0][HID_N-1:0][7:0] fc2_w;
    logic                             start, busy, done, pbusy, pdone;
    logic [OUT_N-1:0][ACC_W-1:0]      logits, plogits;
    logic [0:0]                       class_idx, pclass;

    logic [7:0] w1 [HID_N][B*NUM_PE];
    int hs, phs, checks, failures;
    bit pad_chk;

    typedef struct {
        logic [OUT_N-1:0][ACC_W-1:0] lg;
        int cls;
    } exp_t;
    exp_t q[$];
    exp_t me;

    always #5 clk = ~clk;

    fcn_mlp_engine u_dut (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .w_data(w_data), .w_valid(w_valid),
        .w_ready(w_ready), .fc1_bias(fc1_bias), .cfg_shift(cfg_shift), .fc2_w(fc2_w),
        .start(start), .busy(busy), .done(done), .logits(logits), .class_idx(class_idx)
    );

    fcn_mlp_engine #(.IN1_N(PAD_N)) u_pad (
        .clk(clk), .rst_n(rst_n), .in_vec(in_vec[PAD_N-1:0]), .w_data(pw_data), .w_valid(w_valid),
        .w_ready(pw_ready), .fc1_bias(fc1_bias), .cfg_shift(cfg_shift), .fc2_w(fc2_w),
        .start(start), .busy(pbusy), .done(pdone), .logits(plogits), .class_idx(pclass)
    );

    // weight source: serve the beat selected by the number of accepted handshakes
    always_comb
        for (int p = 0; p < NUM_PE; p++) begin
            w_data[p]  = hs < HID_N * B ? w1[hs / B][(hs % B) * NUM_PE + p] : 8'd0;
            pw_data[p] = (phs % B == B - 1 && p >= 2) ? 8'd127 : 8'd1;
        end

    // handshake counters, restarted on reset or on an accepted start
    always @(posedge clk) begin
        hs  <= (!rst_n || (start && !busy))  ? 0 : hs  + int'(w_valid && w_ready);
        phs <= (!rst_n || (start && !pbusy)) ? 0 : phs + int'(w_valid && pw_ready);
    end

    function void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic exp_t model();
        exp_t e;
        longint s, l, best;
        longint hid [HID_N];
        for (int n = 0; n < HID_N; n++) begin
            s = $signed(fc1_bias[n]);
            for (int i = 0; i < IN1_N; i++) s += $signed(w1[n][i]) * longint'(in_vec[i]);
            if (s < 0) hid[n] = 0;
            else hid[n] = (s + (cfg_shift != 0 ? longint'(1) << (cfg_shift - 1) : 0)) >> cfg_shift;
            if (hid[n] > 255) hid[n] = 255;
        end
        best = 0;
        e.cls = 0;
        for (int o = 0; o < OUT_N; o++) begin
            l = 0;
            for (int k = 0; k < HID_N; k++) l += $signed(fc2_w[o][k]) * hid[k];
            if (l >= (longint'(1) << (ACC_W - 1))) l = (longint'(1) << (ACC_W - 1)) - 1;
            if (l < -(longint'(1) << (ACC_W - 1))) l = -(longint'(1) << (ACC_W - 1));
            e.lg[o] = ACC_W'(l);
            if (o == 0 || l > best) begin
                best = l;
                e.cls = o;
            end
        end
        return e;
    endfunction

    // monitor: every done pulse consumes one expected result
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done: done with no outstanding inference");
            end else begin
                me = q.pop_front();
                for (int o = 0; o < OUT_N; o++) chk($sformatf("logit%0d", o), $signed(logits[o]), $signed(me.lg[o]));
                chk("class_idx", class_idx, me.cls);
                chk("beats", hs, HID_N * B);
            end
        end
        if (rst_n && pdone && pad_chk) begin
            chk("pad_logit0", $signed(plogits[0]), 1300);
            chk("pad_logit1", $signed(plogits[1]), -1300);
            chk("pad_class", pclass, 0);
        end
    end

    task automatic fill(input int iv, input int wv, input int bv, input int sh);
        for (int i = 0; i < IN1_N; i++) in_vec[i] = 8'(iv);
        for (int n = 0; n < HID_N; n++) begin
            for (int i = 0; i < B * NUM_PE; i++) w1[n][i] = 8'(wv);
            fc1_bias[n] = ACC_W'(bv);
        end
        cfg_shift = 5'(sh);
        for (int o = 0; o < OUT_N; o++)
            for (int k = 0; k < HID_N; k++) fc2_w[o][k] = o == 0 ? 8'd1 : 8'hFF;
    endtask

    task automatic rnd();
        for (int i = 0; i < IN1_N; i++) in_vec[i] = 8'($urandom);
        for (int n = 0; n < HID_N; n++) begin
            for (int i = 0; i < B * NUM_PE; i++) w1[n][i] = 8'($urandom);
            fc1_bias[n] = ACC_W'(int'($urandom_range(0, 4000)) - 2000);
        end
        cfg_shift = 5'($urandom_range(7, 12));
        for (int o = 0; o < OUT_N; o++)
            for (int k = 0; k < HID_N; k++) fc2_w[o][k] = 8'($urandom);
    endtask

    // mode 0: valid held, 1: valid toggling, 2: random valid
    task automatic run(input int mode, input bit hold, input int abort_at, input int exp_lat);
        int c;
        q.push_back(model());
        @(negedge clk);
        start = 1;
        w_valid = mode != 1;
        c = 0;
        while (c < 3000) begin
            @(negedge clk);
            c++;
            if (!hold) start = 0;
            w_valid = mode == 0 ? 1'b1 : mode == 1 ? !w_valid : 1'($urandom_range(0, 1));
            if (hold && c == 200) chk("busy_while_start_held", busy, 1);
            if (abort_at >= 0 && hs >= abort_at) begin
                rst_n = 0;
                start = 0;
                @(negedge clk);
                q.delete();
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_w_ready", w_ready, 0);
                chk("rst_logit0", logits[0], 0);
                chk("rst_logit1", logits[1], 0);
                chk("rst_class", class_idx, 0);
                rst_n = 1;
                return;
            end
            if (done) break;
        end
        start = 0;
        if (c >= 3000) begin
            checks++;
            failures++;
            $display("FAIL timeout: no done after %0d cycles", c);
        end else if (exp_lat > 0) chk("latency", c, exp_lat);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        pad_chk = 0;
        start = 0;
        w_valid = 0;
        fill(1, 1, 0, 0);
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_w_ready", w_ready, 0);
        chk("reset_logit0", logits[0], 0);
        chk("reset_logit1", logits[1], 0);
        chk("reset_class", class_idx, 0);
        rst_n = 1;
        @(negedge clk);
        pad_chk = 1;
        run(0, 0, -1, 361);
        pad_chk = 0;
        run(1, 0, -1, 691);
        fill(255, 127, 0, 0);
        run(0, 0, -1, 361);
        fill(255, 127, 0, 14);
        run(0, 0, -1, 361);
        fill(255, 127, 0, 15);
        run(0, 0, -1, 361);
        fill(1, -1, 0, 0);
        run(0, 0, -1, 361);
        fill(1, 1, -100, 0);
        run(0, 0, -1, 361);
        fill(1, 1, 0, 0);
        run(0, 1, -1, 361);
        rnd();
        run(0, 0, 4 * B + 10, 0);
        run(0, 0, -1, 361);
        for (int r = 0; r < 8; r++) begin
            rnd();
            run(r % 3, 0, -1, r % 3 == 0 ? 361 : r % 3 == 1 ? 691 : 0);
        end
        repeat (50) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
